// File: rtl/scan_pkg.sv
// Shared state encoding and code-width constants for the decoder scan sequencer.
package scan_pkg;

  localparam int CODE_W   = 4;
  localparam int MAX_CODE = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scan_prescaler.sv
// 8-bit tick generator: one-cycle tick every PRESCALE enabled cycles, synchronous clear.
module scan_prescaler
  import scan_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [7:0] TOP = 8'(PRESCALE - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TOP) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == TOP);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Drives I3..I0/en of a 4-to-16 decoder, scanning 0..LAST up or down, one-shot or continuous.
// Optional macro SCAN_BLANK_EN inserts a one-cycle en=0 blank at every code change.
module decoder_scan_sequencer
  import scan_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int LAST     = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic mode,
  input  logic dir,
  output logic I0,
  output logic I1,
  output logic I2,
  output logic I3,
  output logic en,
  output logic busy,
  output logic done
);

  localparam logic [CODE_W-1:0] LAST_C = CODE_W'((LAST > MAX_CODE) ? MAX_CODE : LAST);

`ifdef SCAN_BLANK_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mode_q, mode_d;
  logic              dir_q, dir_d;
  logic              tick;
  logic              at_end;
  logic [CODE_W-1:0] start_val;

  // Prescaler only advances while en is high, so a blank cycle never eats into a code's hold time.
  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q != S_RUN),
    .en_i   (en_q),
    .tick_o (tick)
  );

  assign at_end    = dir_q ? (code_q == '0) : (code_q == LAST_C);
  assign start_val = dir_q ? LAST_C : '0;

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    en_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    mode_d  = mode_q;
    dir_d   = dir_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_RUN;
          code_d  = dir ? LAST_C : '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          mode_d  = mode;
          dir_d   = dir;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          busy_d = 1'b1;
          en_d   = 1'b1;
          if (tick) begin
            if (!at_end) begin
              code_d = dir_q ? code_q - 4'd1 : code_q + 4'd1;
              en_d   = !BLANK;
            end else if (mode_q) begin
              code_d = start_val;
              en_d   = !BLANK;
            end else begin
              state_d = S_DONE;
              en_d    = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  assign I0   = code_q[0];
  assign I1   = code_q[1];
  assign I2   = code_q[2];
  assign I3   = code_q[3];
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Scoreboard bench for decoder_scan_sequencer; blank-cycle scenario runs when SCAN_BLANK_EN is defined.
module tb_decoder_scan_sequencer;

`ifdef SCAN_BLANK_EN
  localparam int P = 2;
  localparam int L = 3;
`else
  localparam int P = 4;
  localparam int L = 15;
`endif

  logic clk = 1'b0;
  logic rst, start, stop, mode, dir;
  logic I0, I1, I2, I3, en, busy, done;

  typedef struct {
    logic       en;
    logic       busy;
    logic       done;
    logic [3:0] code;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  decoder_scan_sequencer #(
    .PRESCALE (P),
    .LAST     (L)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dir   (dir),
    .I0    (I0),
    .I1    (I1),
    .I2    (I2),
    .I3    (I3),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [6:0] act, input logic [6:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: en,busy,done,code got %b required %b", name, act, req);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared just after the edge.
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      compare(e.name, {en, busy, done, I3, I2, I1, I0}, {e.en, e.busy, e.done, e.code});
    end
  end

  // Drive inputs for the coming edge and queue the state expected after it.
  task automatic cyc(input logic s, input logic p, input logic m, input logic d,
                     input logic e_en, input logic e_busy, input logic e_done,
                     input logic [3:0] e_code, input string name);
    exp_t e;
    start = s; stop = p; mode = m; dir = d;
    e.en = e_en; e.busy = e_busy; e.done = e_done; e.code = e_code; e.name = name;
    q.push_back(e);
    @(negedge clk);
  endtask

`ifdef SCAN_BLANK_EN
  logic [3:0] c6 [10] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};
  logic       e6 [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; dir = 1'b0;
    #1;
    compare("reset_state", {en, busy, done, I3, I2, I1, I0}, 7'b0);
    @(negedge clk);
    rst = 1'b0;

`ifdef SCAN_BLANK_EN
    // One-shot up with blank cycles at every code change.
    cyc(1, 0, 0, 0, 1, 1, 0, 4'd0, "t6_start");
    for (int n = 0; n < 10; n++) cyc(0, 0, 0, 0, e6[n], 1, 0, c6[n], "t6_run");
    cyc(0, 0, 0, 0, 0, 0, 1, 4'd3, "t6_done");
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd3, "t6_idle");
    // Continuous run stopped during a blank cycle.
    cyc(1, 0, 1, 0, 1, 1, 0, 4'd0, "t6c_start");
    cyc(0, 0, 0, 0, 1, 1, 0, 4'd0, "t6c_hold");
    cyc(0, 0, 0, 0, 0, 1, 0, 4'd1, "t6c_blank");
    cyc(0, 1, 0, 0, 0, 0, 0, 4'd1, "t6c_stop_in_blank");
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd1, "t6c_idle");
`else
    // 1: one-shot up; mode/dir inputs toggled during the run must be ignored.
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd0, "t1_idle");
    cyc(1, 0, 0, 0, 1, 1, 0, 4'd0, "t1_start");
    for (int n = 1; n < 64; n++) cyc(0, 0, 1, 1, 1, 1, 0, 4'(n / 4), "t1_run");
    cyc(0, 0, 0, 0, 0, 0, 1, 4'd15, "t1_done");
    cyc(1, 0, 0, 0, 0, 0, 0, 4'd15, "t1_start_in_done");
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd15, "t1_idle_after");

    // 2: continuous down, wraps 0 -> 15 without a gap; stop coincides with a tick.
    cyc(1, 0, 1, 1, 1, 1, 0, 4'd15, "t2_start");
    for (int n = 1; n < 72; n++) cyc(0, 0, 0, 0, 1, 1, 0, 4'(15 - ((n / 4) % 16)), "t2_run");
    cyc(0, 1, 0, 0, 0, 0, 0, 4'd14, "t2_stop_on_tick");
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd14, "t2_idle");

    // 3: stop at code 7, then start+stop together, then restart from 0.
    cyc(1, 0, 0, 0, 1, 1, 0, 4'd0, "t3_start");
    for (int n = 1; n < 30; n++) cyc(0, 0, 0, 0, 1, 1, 0, 4'(n / 4), "t3_run");
    cyc(0, 1, 0, 0, 0, 0, 0, 4'd7, "t3_stop");
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd7, "t3_frozen");
    cyc(1, 1, 0, 0, 0, 0, 0, 4'd7, "t5_start_and_stop");
    cyc(0, 0, 0, 0, 0, 0, 0, 4'd7, "t5_still_idle");
    cyc(1, 0, 1, 0, 1, 1, 0, 4'd0, "t3_restart");
    // 5: start pulse at code 3 must not disturb timing.
    for (int n = 1; n < 22; n++) cyc(n == 13, 0, 0, 0, 1, 1, 0, 4'(n / 4), "t5_run");
    cyc(0, 1, 0, 0, 0, 0, 0, 4'd5, "t5_stop");

    // 4: asynchronous reset at code 5, mid-prescale.
    cyc(1, 0, 0, 0, 1, 1, 0, 4'd0, "t4_start");
    for (int n = 1; n < 23; n++) cyc(0, 0, 0, 0, 1, 1, 0, 4'(n / 4), "t4_run");
    rst = 1'b1;
    #1;
    compare("t4_async_reset", {en, busy, done, I3, I2, I1, I0}, 7'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) cyc(0, 0, 0, 0, 0, 0, 0, 4'd0, "t4_idle_after_reset");
`endif

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
